// File: rtl/ddr3_dqs_delay_trainer.sv
// ddr3_dqs_delay_trainer: centres one DDR3 DQS lane by stepping its IOD RX delay line on eye-monitor flags
module ddr3_dqs_delay_trainer #(
  parameter int INIT_TAP      = 1,
  parameter int MAX_TAP       = 127,
  parameter int SETTLE_CYCLES = 8,
  parameter int LOCK_COUNT    = 4,
  parameter int MAX_ITER      = 255
) (
  input  logic       FAB_CLK,
  input  logic       ARST_N,
  input  logic       start,
  input  logic       EYE_MONITOR_EARLY,
  input  logic       EYE_MONITOR_LATE,
  input  logic       DELAY_LINE_OUT_OF_RANGE,
  output logic       DELAY_LINE_LOAD,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIRECTION,
  output logic       EYE_MONITOR_CLEAR_FLAGS,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [7:0] tap_pos
);
  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, SETTLE, SAMPLE, MOVE, DONE, ERROR} state_t;
  localparam logic [7:0] TAP_INIT    = 8'(INIT_TAP);
  localparam logic [7:0] TAP_MAX     = 8'(MAX_TAP);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LOCK_LIM    = 8'(LOCK_COUNT);
  localparam logic [7:0] ITER_LIM    = 8'(MAX_ITER);
  state_t     state, nxt;
  logic [7:0] settle_cnt, lock_cnt, iter_cnt;
  logic       dir_nxt, early, late, clean;
  logic [1:0] code_nxt;
  assign early = EYE_MONITOR_EARLY & ~EYE_MONITOR_LATE;
  assign late  = EYE_MONITOR_LATE & ~EYE_MONITOR_EARLY;
  assign clean = ~EYE_MONITOR_EARLY & ~EYE_MONITOR_LATE;
  always_ff @(posedge FAB_CLK or negedge ARST_N)
    if (!ARST_N) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt      = state;
    dir_nxt  = DELAY_LINE_DIRECTION;
    code_nxt = err_code;
    case (state)
      IDLE, DONE, ERROR: if (start) begin
        nxt      = LOAD;
        code_nxt = 2'd0;
      end
      LOAD:   nxt = CLEAR;
      CLEAR:  nxt = SETTLE;
      SETTLE: nxt = settle_cnt == SETTLE_LAST ? SAMPLE : SETTLE;
      SAMPLE:
        if (DELAY_LINE_OUT_OF_RANGE) begin
          nxt      = ERROR;
          code_nxt = 2'd2;
        end else if (iter_cnt + 8'd1 == ITER_LIM) begin
          nxt      = ERROR;
          code_nxt = 2'd3;
        end else if (early) begin
          dir_nxt  = 1'b1;
          nxt      = tap_pos == TAP_MAX ? ERROR : MOVE;
          code_nxt = tap_pos == TAP_MAX ? 2'd1 : err_code;
        end else if (late) begin
          dir_nxt  = 1'b0;
          nxt      = tap_pos == 8'd0 ? ERROR : MOVE;
          code_nxt = tap_pos == 8'd0 ? 2'd1 : err_code;
        end else if (clean) nxt = lock_cnt + 8'd1 == LOCK_LIM ? DONE : CLEAR;
        else nxt = CLEAR;
      MOVE:    nxt = CLEAR;
      default: nxt = IDLE;
    endcase
  end
  // Outputs are registered from the next state so each pulse is aligned with its state cycle.
  always_ff @(posedge FAB_CLK or negedge ARST_N)
    if (!ARST_N) begin
      DELAY_LINE_LOAD         <= 1'b0;
      DELAY_LINE_MOVE         <= 1'b0;
      DELAY_LINE_DIRECTION    <= 1'b0;
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
      busy                    <= 1'b0;
      done                    <= 1'b0;
      error                   <= 1'b0;
      err_code                <= 2'd0;
      tap_pos                 <= TAP_INIT;
      settle_cnt              <= 8'd0;
      lock_cnt                <= 8'd0;
      iter_cnt                <= 8'd0;
    end else begin
      DELAY_LINE_LOAD         <= nxt == LOAD;
      DELAY_LINE_MOVE         <= nxt == MOVE;
      EYE_MONITOR_CLEAR_FLAGS <= nxt == CLEAR;
      DELAY_LINE_DIRECTION    <= dir_nxt;
      busy                    <= !(nxt inside {IDLE, DONE, ERROR});
      done                    <= nxt == DONE;
      error                   <= nxt == ERROR;
      err_code                <= code_nxt;
      settle_cnt              <= state == SETTLE ? settle_cnt + 8'd1 : 8'd0;
      if (nxt == LOAD) begin
        lock_cnt <= 8'd0;
        iter_cnt <= 8'd0;
      end else if (state == SAMPLE) begin
        iter_cnt <= iter_cnt + 8'd1;
        lock_cnt <= clean ? lock_cnt + 8'd1 : 8'd0;
      end
      if (state == LOAD) tap_pos <= TAP_INIT;
      else if (state == MOVE)
        tap_pos <= DELAY_LINE_DIRECTION ? (tap_pos == TAP_MAX ? tap_pos : tap_pos + 8'd1)
                                        : (tap_pos == 8'd0 ? tap_pos : tap_pos - 8'd1);
    end
endmodule
